// File: rtl/button_conditioner.sv
// Synchronizes and debounces the active-low Run and ClearA_LoadB buttons, queues one
// Run behind Busy, and issues single-cycle requests. The S switch bus is only synchronized.

module button_conditioner_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic btn_n,
    output logic press
);
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q,  sync1_d;
    logic             sync2_q,  sync2_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             stable_q, stable_d;
    logic             press_q,  press_d;

    // NOTE: every _d gets a default before any branch, so no path can infer a latch.
    always_comb begin
        sync1_d  = btn_n;
        sync2_d  = sync1_q;
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Only the released-to-pressed transition is an event; release is silent.
        press_d = stable_q & ~stable_d;
    end

    // NOTE: Reset is synchronous, so it is tested inside the clocked block and is not
    // in the sensitivity list; state updates use non-blocking assignments.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            cnt_q    <= '0;
            stable_q <= 1'b1;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            press_q  <= press_d;
        end
    end

    assign press = press_q;

endmodule

module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run_n,
    input  logic       ClearA_LoadB_n,
    input  logic [7:0] S_raw,
    input  logic       Busy,
    output logic       Run_pulse,
    output logic       ClearA_LoadB_pulse,
    output logic       Run_pending,
    output logic [7:0] S_sync
);
    typedef enum logic {
        PEND_IDLE   = 1'b0,
        PEND_QUEUED = 1'b1
    } pend_state_e;

    if (DEBOUNCE_CYCLES < 2) begin : g_param_check
        $error("DEBOUNCE_CYCLES must be at least 2");
    end

    logic        run_press;
    logic        clr_press;
    pend_state_e state_q,     state_d;
    logic        run_pulse_q, run_pulse_d;
    logic        clr_pulse_q, clr_pulse_d;
    logic [7:0]  s_meta_q,    s_meta_d;
    logic [7:0]  s_sync_q,    s_sync_d;

    button_conditioner_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_run_debounce (
        .Clk   (Clk),
        .Reset (Reset),
        .btn_n (Run_n),
        .press (run_press)
    );

    button_conditioner_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_clr_debounce (
        .Clk   (Clk),
        .Reset (Reset),
        .btn_n (ClearA_LoadB_n),
        .press (clr_press)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= PEND_IDLE;
            run_pulse_q <= 1'b0;
            clr_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_pulse_q <= run_pulse_d;
            clr_pulse_q <= clr_pulse_d;
        end
    end

    // A Clear press owns the cycle: it either fires (idle) or is dropped (busy),
    // and in both cases any same-cycle Run activity is suppressed.
    always_comb begin
        state_d = state_q;
        if (clr_press) begin
            if (!Busy) begin
                state_d = PEND_IDLE;
            end
        end else if (Busy) begin
            if (run_press) begin
                state_d = PEND_QUEUED;
            end
        end else begin
            state_d = PEND_IDLE;
        end
    end

    always_comb begin
        clr_pulse_d = clr_press & ~Busy;
        run_pulse_d = ~clr_press & ~Busy & (run_press | (state_q == PEND_QUEUED));
    end

    always_comb begin
        s_meta_d = S_raw;
        s_sync_d = s_meta_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s_meta_q <= 8'h00;
            s_sync_q <= 8'h00;
        end else begin
            s_meta_q <= s_meta_d;
            s_sync_q <= s_sync_d;
        end
    end

    assign Run_pulse          = run_pulse_q;
    assign ClearA_LoadB_pulse = clr_pulse_q;
    assign Run_pending        = (state_q == PEND_QUEUED);
    assign S_sync             = s_sync_q;

endmodule
